decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Next-gen decode stage: decodes 16-bit cpu instructions into control fields, buffers them in a
//  DEPTH-entry queue with valid/ready handshakes on both sides, and supports an EXT prefix that
//  widens the immediate to 16 bits. Sits between fetch and execute; flush drops all in-flight work.
// PARAMETERS
//  DEPTH        2  decoded-entry queue depth; power of 2, >=2
//  EXT_EN       1  1: type 00 subop 111 is the EXT prefix; 0: it is an ordinary type-00 instruction
//  ILLEGAL_TRAP 1  1: after an illegal instruction is enqueued, stop accepting until flush
// PORTS
//  clk            in   1   clock, posedge
//  rst            in   1   reset; asynchronous, active-high
//  flush          in   1   drop queue and prefix state; no accept this cycle
//  in_valid       in   1   inst valid from fetch
//  in_ready       out  1   decode can accept inst
//  inst           in   16  instruction: [1:0] type, [4:2] subop, [7:5] reg, [15:8] imm
//  out_valid      out  1   head entry valid
//  out_ready      in   1   execute consumes head
//  immediate      out  16  {hi, inst[15:8]}; hi = EXT byte if prefixed, else 8'h00
//  inst_type      out  2   inst[1:0]
//  subop          out  3   inst[4:2]
//  rf_write_addr  out  3   destination register
//  rX_addr        out  3   source register
//  rf_we          out  1   instruction writes rf_write_addr
//  rx_re          out  1   instruction reads rX_addr
//  alu_operation  out  alu_operation_t  cpu_common ALU op, from subop (000 SL .. 111 MUL)
//  wb_src         out  2   0 ALU, 1 MEM, 2 REG (move), 3 IMM; 0 when rf_we=0
//  illegal        out  1   head entry is an illegal encoding
//  count          out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: queue empty, count=0, out_valid=0, state IDLE, all storage and output fields 0, in_ready=0
//   while rst high, 1 the first cycle after.
//  Accept = in_valid & in_ready. in_ready = (count<DEPTH) & state!=TRAP & !flush. No full bypass:
//   pop while full does not open in_ready that cycle. Pop = out_valid & out_ready.
//  Latency: inst accepted at edge N is at head (if queue was empty) with out_valid=1 after edge N.
//  Push+pop same cycle: count unchanged; order preserved. Pointers wrap mod DEPTH.
//  Output fields always reflect the head slot; hold stable while out_valid & !out_ready.
//  Decode table (unlisted fields 0):
//   type 01 sub 000 PUSH: rx_re, rX=inst[7:5]
//   type 01 sub 001 POP: rf_we, wr=inst[7:5], wb MEM
//   type 01 sub 010-111 ALU: rf_we wr=0, rx_re rX=inst[7:5], wb ALU
//   type 10: rf_we, rx_re, wr=rX=inst[7:5], wb IMM
//   type 11 inst[7:2]=100000 0TOX: rf_we wr=inst[10:8], rx_re rX=0, wb REG
//   type 11 inst[7:2]=100001 XTO0: rf_we wr=0, rx_re rX=inst[10:8], wb REG
//   type 11 inst[7:2]=110000/110001 SL/SR: rf_we wr=0, rx_re rX=0, wb ALU
//   type 11 any other: illegal=1, rf_we=rx_re=0
//   type 00: no register access (EXT handled below)
//  State machine IDLE/PREFIX/TRAP:
//   IDLE, accept EXT (EXT_EN=1): not enqueued; hi<=inst[15:8]; ->PREFIX.
//   PREFIX, accept non-EXT: enqueued with immediate {hi,inst[15:8]}; ->IDLE.
//   PREFIX, accept EXT: hi replaced; stay PREFIX (earlier prefix dropped).
//   Accept illegal with ILLEGAL_TRAP=1: enqueue with illegal=1 (prefix applied/consumed); ->TRAP.
//   TRAP: in_ready=0; queue still drains; exits only by flush or rst.
//  flush: count<=0, out_valid<=0, hi<=0, state<=IDLE next edge; overrides accept and pop.
//  rst mid-operation: immediate return to reset values regardless of handshake in progress.
// TESTING
//  rst, push 16'h0549 (ALU ADD rX=r2) with out_ready=1 -> next cycle out_valid=1, rf_we=1 wr=0,
//   rX=2, rx_re=1, alu ADD, wb ALU, immediate=16'h0005.
//  out_ready=0, push 3 insts with DEPTH=2 -> in_ready=0 after 2nd, count=2, 3rd held; raise
//   out_ready -> FIFO order, 3rd accepted one cycle after a pop frees a slot.
//  push EXT 16'hAB1C then 16'h12E2 (type 10, r7) -> one entry, immediate=16'hAB12, wr=rX=7, wb IMM.
//  push 16'h0000 0x... type 11 inst[7:2]=111111 (16'h00FF) -> illegal=1, in_ready=0 until flush;
//   flush -> count=0, out_valid=0, in_ready=1 next cycle.
//  full queue, pop and in_valid same cycle -> count stays DEPTH, no accept; EXT then flush -> next
//   inst gets immediate hi=8'h00.
//  assert rst while count=2 and state PREFIX -> outputs 0, count=0 immediately (async).

Source files
------------

// File: rtl/decode_queue.sv
// Decode stage for the 16-bit cpu: turns fetched instructions into control fields and buffers
// them in a small valid/ready queue. An EXT prefix supplies the upper immediate byte of the next instruction.

package cpu_common;
    typedef enum logic [2:0] {
        ALU_SL  = 3'd0,
        ALU_SR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_MUL = 3'd7
    } alu_operation_t;
endpackage

module decode_queue #(
    parameter int DEPTH        = 2,
    parameter bit EXT_EN       = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   inst,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   immediate,
    output logic [1:0]                    inst_type,
    output logic [2:0]                    subop,
    output logic [2:0]                    rf_write_addr,
    output logic [2:0]                    rX_addr,
    output logic                          rf_we,
    output logic                          rx_re,
    output cpu_common::alu_operation_t    alu_operation,
    output logic [1:0]                    wb_src,
    output logic                          illegal,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PREFIX = 2'd1;
    localparam logic [1:0] ST_TRAP   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_REG = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  typ;
        logic [2:0]  sub;
        logic [2:0]  wr;
        logic [2:0]  rx;
        logic        we;
        logic        re;
        logic [1:0]  wb;
        logic        ill;
    } entry_t;

    entry_t          slot_reg [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [7:0]      hi_reg;
    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [7:0]      hi_next;

    entry_t          dec;
    entry_t          head;
    logic            is_ext;
    logic            accept;
    logic            push;
    logic            pop;

    assign is_ext = EXT_EN && (inst[1:0] == 2'b00) && (inst[4:2] == 3'b111);

    // rst is folded in so in_ready stays low for the whole reset pulse
    assign in_ready = !rst && !flush && (count_reg < DEPTH_C) && (state_reg != ST_TRAP);
    assign accept   = in_valid && in_ready;
    assign push     = accept && !is_ext;
    assign out_valid = (count_reg != '0);
    assign pop      = out_valid && out_ready && !flush;

    always_comb begin
        dec     = '0;
        dec.imm = {(state_reg == ST_PREFIX) ? hi_reg : 8'h00, inst[15:8]};
        dec.typ = inst[1:0];
        dec.sub = inst[4:2];
        case (inst[1:0])
            2'b01: begin
                case (inst[4:2])
                    3'b000: begin
                        dec.re = 1'b1;
                        dec.rx = inst[7:5];
                    end
                    3'b001: begin
                        dec.we = 1'b1;
                        dec.wr = inst[7:5];
                        dec.wb = WB_MEM;
                    end
                    default: begin
                        dec.we = 1'b1;
                        dec.re = 1'b1;
                        dec.rx = inst[7:5];
                        dec.wb = WB_ALU;
                    end
                endcase
            end
            2'b10: begin
                dec.we = 1'b1;
                dec.re = 1'b1;
                dec.wr = inst[7:5];
                dec.rx = inst[7:5];
                dec.wb = WB_IMM;
            end
            2'b11: begin
                case (inst[7:2])
                    6'b100000: begin
                        dec.we = 1'b1;
                        dec.wr = inst[10:8];
                        dec.re = 1'b1;
                        dec.wb = WB_REG;
                    end
                    6'b100001: begin
                        dec.we = 1'b1;
                        dec.re = 1'b1;
                        dec.rx = inst[10:8];
                        dec.wb = WB_REG;
                    end
                    6'b110000, 6'b110001: begin
                        dec.we = 1'b1;
                        dec.re = 1'b1;
                        dec.wb = WB_ALU;
                    end
                    default: dec.ill = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Any accepted non-EXT instruction consumes the pending prefix byte
    always_comb begin
        state_next = state_reg;
        hi_next    = hi_reg;
        if (accept) begin
            if (is_ext) begin
                hi_next    = inst[15:8];
                state_next = ST_PREFIX;
            end else begin
                hi_next    = 8'h00;
                state_next = (ILLEGAL_TRAP && dec.ill) ? ST_TRAP : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hi_reg     <= 8'h00;
            state_reg  <= ST_IDLE;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hi_reg     <= 8'h00;
            state_reg  <= ST_IDLE;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            hi_reg    <= hi_next;
            state_reg <= state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    slot_reg[gi] <= '0;
                else if (push && (wr_ptr_reg == PW'(gi)))
                    slot_reg[gi] <= dec;
            end
        end
    endgenerate

    assign head          = slot_reg[rd_ptr_reg];
    assign immediate     = head.imm;
    assign inst_type     = head.typ;
    assign subop         = head.sub;
    assign rf_write_addr = head.wr;
    assign rX_addr       = head.rx;
    assign rf_we         = head.we;
    assign rx_re         = head.re;
    assign wb_src        = head.wb;
    assign illegal       = head.ill;
    assign alu_operation = cpu_common::alu_operation_t'(head.sub);
    assign count         = count_reg;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues hand-computed decodes, a monitor
// compares them against every head entry that execute consumes.

module tb_decode_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] immediate;
    logic [1:0]  inst_type;
    logic [2:0]  subop;
    logic [2:0]  rf_write_addr;
    logic [2:0]  rX_addr;
    logic        rf_we;
    logic        rx_re;
    cpu_common::alu_operation_t alu_operation;
    logic [1:0]  wb_src;
    logic        illegal;
    logic [1:0]  count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [34:0] sb[$];

    decode_queue #(.DEPTH(2), .EXT_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .immediate(immediate), .inst_type(inst_type), .subop(subop),
        .rf_write_addr(rf_write_addr), .rX_addr(rX_addr),
        .rf_we(rf_we), .rx_re(rx_re), .alu_operation(alu_operation),
        .wb_src(wb_src), .illegal(illegal), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // {imm, type, subop, wr, rX, rf_we, rx_re, wb, illegal, alu}
    function automatic logic [34:0] ex(input logic [15:0] imm, input logic [1:0] t, input logic [2:0] s,
                                       input logic [2:0] wr, input logic [2:0] rx, input logic we,
                                       input logic re, input logic [1:0] wb, input logic ill,
                                       input logic [2:0] alu);
        return {imm, t, s, wr, rx, we, re, wb, ill, alu};
    endfunction

    // Waits (bounded) for the handshake; the expected decode is queued when acceptance is certain
    task automatic push(input logic [15:0] i, input logic has_exp, input logic [34:0] e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        inst     = i;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (has_exp)
                    sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_assert++;
            n_fail++;
            $display("FAIL push_timeout: got no accept expected accept of %h", i);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [34:0] got;
        logic [34:0] exp_v;
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid && out_ready) begin
                got = {immediate, inst_type, subop, rf_write_addr, rX_addr, rf_we, rx_re,
                       wb_src, illegal, 3'(alu_operation)};
                if (sb.size() == 0) begin
                    check("unexpected_output", {29'd0, got}, 64'd0);
                end else begin
                    exp_v = sb.pop_front();
                    $display("txn: head %h expected %h", got, exp_v);
                    check("head_entry", {29'd0, got}, {29'd0, exp_v});
                end
            end
        end
    end

    initial begin : stimulus
        logic [34:0] e0549, e1025, e2061, e3583, e12e2_ab, e12e2_00, e0687, e00c3, e4404, e00ff;
        e0549    = ex(16'h0005, 2'b01, 3'b010, 3'd0, 3'd2, 1'b1, 1'b1, 2'd0, 1'b0, 3'd2);
        e1025    = ex(16'h0010, 2'b01, 3'b001, 3'd1, 3'd0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd1);
        e2061    = ex(16'h0020, 2'b01, 3'b000, 3'd0, 3'd3, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0);
        e3583    = ex(16'h0035, 2'b11, 3'b000, 3'd5, 3'd0, 1'b1, 1'b1, 2'd2, 1'b0, 3'd0);
        e12e2_ab = ex(16'hAB12, 2'b10, 3'b000, 3'd7, 3'd7, 1'b1, 1'b1, 2'd3, 1'b0, 3'd0);
        e12e2_00 = ex(16'h0012, 2'b10, 3'b000, 3'd7, 3'd7, 1'b1, 1'b1, 2'd3, 1'b0, 3'd0);
        e0687    = ex(16'h0006, 2'b11, 3'b001, 3'd0, 3'd6, 1'b1, 1'b1, 2'd2, 1'b0, 3'd1);
        e00c3    = ex(16'h0000, 2'b11, 3'b000, 3'd0, 3'd0, 1'b1, 1'b1, 2'd0, 1'b0, 3'd0);
        e4404    = ex(16'h0044, 2'b00, 3'b001, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1);
        e00ff    = ex(16'h0000, 2'b11, 3'b111, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd7);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = 16'h0000; out_ready = 1'b0;
        #3;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_immediate", 64'(immediate), 64'd0);
        idle(2);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // single ALU ADD, one-cycle latency to head
        out_ready = 1'b1;
        push(16'h0549, 1'b1, e0549);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("latency_count", 64'(count), 64'd1);
        idle(2);
        check("drained_count", 64'(count), 64'd0);

        // fill, hold third, no bypass while full
        out_ready = 1'b0;
        push(16'h1025, 1'b1, e1025);
        push(16'h2061, 1'b1, e2061);
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        inst = 16'h3583;
        @(negedge clk);
        check("third_held_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("third_held_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("no_bypass_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("after_pop_count", 64'(count), 64'd1);
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        push(16'h3583, 1'b1, e3583);
        check("push_pop_count", 64'(count), 64'd1);
        idle(3);
        check("drain2_count", 64'(count), 64'd0);

        // EXT prefix and other decode rows
        push(16'hAB1C, 1'b0, 35'd0);
        check("ext_not_enqueued", 64'(count), 64'd0);
        push(16'h12E2, 1'b1, e12e2_ab);
        push(16'h0687, 1'b1, e0687);
        push(16'h00C3, 1'b1, e00c3);
        push(16'h4404, 1'b1, e4404);
        idle(3);
        check("drain3_count", 64'(count), 64'd0);

        // illegal traps until flush
        push(16'h00FF, 1'b1, e00ff);
        check("trap_in_ready", 64'(in_ready), 64'd0);
        idle(3);
        check("trap_drained_count", 64'(count), 64'd0);
        check("trap_still_blocked", 64'(in_ready), 64'd0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        idle(1);
        flush = 1'b0;
        #1;
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_out_valid", 64'(out_valid), 64'd0);
        check("post_flush_in_ready", 64'(in_ready), 64'd1);

        // flush drops queued entries and a pending prefix
        out_ready = 1'b0;
        push(16'h0549, 1'b0, 35'd0);
        push(16'hAB1C, 1'b0, 35'd0);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("flush_drop_count", 64'(count), 64'd0);
        check("flush_drop_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        push(16'h12E2, 1'b1, e12e2_00);
        idle(2);

        // asynchronous reset mid-operation with a prefix pending
        out_ready = 1'b0;
        push(16'h1025, 1'b0, 35'd0);
        push(16'hAB1C, 1'b0, 35'd0);
        check("pre_rst_count", 64'(count), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_immediate", 64'(immediate), 64'd0);
        check("async_rst_rf_we", 64'(rf_we), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        idle(1);
        rst = 1'b0;
        #1;
        out_ready = 1'b1;
        push(16'h12E2, 1'b1, e12e2_00);
        idle(3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
